// File: rtl/axis_memory.sv
`default_nettype none
// ============================================================================
// Module   : axis_memory
// Purpose  : Single-clock AXI4-Stream FIFO buffer. Words accepted on the s02
//            stream are stored, together with tstrb and tlast, in a
//            MEM_SIZE-deep array and replayed in order on the m02 stream
//            through a registered output stage.
// Ports    : s02_axis_aclk      - clock for both stream interfaces
//            s02_axis_aresetn   - asynchronous active-low reset (whole block)
//            s02_axis_wr_tdata  - write data
//            s02_axis_tstrb     - byte strobe, stored with the word
//            s02_axis_tvalid    - write word valid
//            s02_axis_tlast     - end-of-packet marker, stored with the word
//            s02_axis_tready    - block can accept a word
//            m02_axis_tready    - consumer accepts the output word
//            m02_axis_rd_tdata  - read data
//            m02_axis_tstrb     - strobe of the output word
//            m02_axis_tvalid    - output word valid
//            m02_axis_tlast     - tlast of the output word
// Revision : 1.0 - initial release
// ============================================================================
module axis_memory #(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    s02_axis_aclk,
  input  logic                    s02_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s02_axis_wr_tdata,
  input  logic [DATA_WIDTH/8-1:0] s02_axis_tstrb,
  input  logic                    s02_axis_tvalid,
  input  logic                    s02_axis_tlast,
  output logic                    s02_axis_tready,
  input  logic                    m02_axis_tready,
  output logic [DATA_WIDTH-1:0]   m02_axis_rd_tdata,
  output logic [DATA_WIDTH/8-1:0] m02_axis_tstrb,
  output logic                    m02_axis_tvalid,
  output logic                    m02_axis_tlast
);

  localparam int                c_STRB_W  = DATA_WIDTH / 8;
  localparam int                c_ENTRY_W = DATA_WIDTH + c_STRB_W + 1;
  localparam logic [ADDR_WIDTH:0] c_FULL  = (ADDR_WIDTH + 1)'(MEM_SIZE);

  // Storage entry layout: {tlast, tstrb, tdata}
  logic [c_ENTRY_W-1:0]  r_mem [MEM_SIZE];

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_occ;      // words held: array plus output register
  logic                  r_active;   // low during reset and the first edge after it
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [c_STRB_W-1:0]   r_m_strb;
  logic                  r_m_last;

  logic                  w_s_ready;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [ADDR_WIDTH:0]   w_arr_cnt;
  logic                  w_load;
  logic [c_ENTRY_W-1:0]  w_rd_word;

  // Ready depends only on registered state, so there is no input-to-ready path
  // and a same-edge read on a full buffer only frees a slot on the next cycle.
  assign w_s_ready = r_active && (r_occ != c_FULL);
  assign w_wr_en   = s02_axis_tvalid && w_s_ready;
  assign w_rd_en   = r_m_valid && m02_axis_tready;

  // Words still sitting in the array; a word written on this edge is not yet
  // counted, which gives the one-cycle extra latency through the buffer.
  assign w_arr_cnt = r_occ - {{ADDR_WIDTH{1'b0}}, r_m_valid};
  assign w_load    = (!r_m_valid || m02_axis_tready) && (w_arr_cnt != '0);
  assign w_rd_word = r_mem[r_rd_ptr];

  // Array has no reset: contents survive reset but are unreachable because
  // the pointers and occupancy are cleared.
  always_ff @(posedge s02_axis_aclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {s02_axis_tlast, s02_axis_tstrb, s02_axis_wr_tdata};
    end
  end

  always_ff @(posedge s02_axis_aclk or negedge s02_axis_aresetn) begin
    if (!s02_axis_aresetn) begin
      r_active  <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_strb  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      r_active <= 1'b1;

      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end

      case ({w_wr_en, w_rd_en})
        2'b10:   r_occ <= r_occ + (ADDR_WIDTH + 1)'(1);
        2'b01:   r_occ <= r_occ - (ADDR_WIDTH + 1)'(1);
        default: r_occ <= r_occ;
      endcase

      if (w_load) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(1);
        r_m_valid <= 1'b1;
        r_m_data  <= w_rd_word[DATA_WIDTH-1:0];
        r_m_strb  <= w_rd_word[DATA_WIDTH +: c_STRB_W];
        r_m_last  <= w_rd_word[c_ENTRY_W-1];
      end else if (w_rd_en) begin
        // Consumed with nothing to replace it: data fields keep the last word.
        r_m_valid <= 1'b0;
      end
    end
  end

  assign s02_axis_tready   = w_s_ready;
  assign m02_axis_tvalid   = r_m_valid;
  assign m02_axis_rd_tdata = r_m_data;
  assign m02_axis_tstrb    = r_m_strb;
  assign m02_axis_tlast    = r_m_last;

endmodule
`default_nettype wire

// File: tb/tb_axis_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_memory
// Purpose  : Self-checking bench for axis_memory: directed vector table,
//            fill/full/drain, long streaming, random stalls and mid-stream
//            reset, all checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_memory;

  localparam int c_MEM  = 4096;
  localparam int c_AW   = 12;
  localparam int c_DW   = 32;

  logic              clk;
  logic              rst_n;
  logic [c_DW-1:0]   s_data;
  logic [c_DW/8-1:0] s_strb;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic              m_ready;
  logic [c_DW-1:0]   m_data;
  logic [c_DW/8-1:0] m_strb;
  logic              m_valid;
  logic              m_last;

  axis_memory #(.MEM_SIZE(c_MEM), .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) dut (
    .s02_axis_aclk     (clk),
    .s02_axis_aresetn  (rst_n),
    .s02_axis_wr_tdata (s_data),
    .s02_axis_tstrb    (s_strb),
    .s02_axis_tvalid   (s_valid),
    .s02_axis_tlast    (s_last),
    .s02_axis_tready   (s_ready),
    .m02_axis_tready   (m_ready),
    .m02_axis_rd_tdata (m_data),
    .m02_axis_tstrb    (m_strb),
    .m02_axis_tvalid   (m_valid),
    .m02_axis_tlast    (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: every word currently held, in order, tagged with the
  // edge number at which it was accepted.
  typedef struct {
    logic [c_DW-1:0]   d;
    logic [c_DW/8-1:0] s;
    logic              l;
    int                k;
  } ent_t;

  ent_t q[$];
  int   n_edge = 0;
  bit   active = 0;

  // Apply one clock: record handshakes from the pre-edge view, advance the
  // clock, then compare the DUT outputs with the model.
  task automatic step();
    bit   wr;
    bit   rd;
    bit   e_ready;
    bit   e_valid;
    ent_t e;
    wr = rst_n && s_valid && s_ready;
    rd = rst_n && m_valid && m_ready;
    if (rd && q.size() > 0) void'(q.pop_front());
    if (wr) begin
      e.d = s_data; e.s = s_strb; e.l = s_last; e.k = n_edge + 1;
      q.push_back(e);
    end
    @(posedge clk);
    n_edge++;
    if (rst_n) active = 1;
    #1;
    e_ready = active && (q.size() < c_MEM);
    e_valid = (q.size() > 0) && (q[0].k < n_edge);
    chk("m_tready_model", 64'(s_ready), 64'(e_ready));
    chk("m_tvalid_model", 64'(m_valid), 64'(e_valid));
    if (e_valid && m_valid) begin
      chk("m_data_model", 64'(m_data), 64'(q[0].d));
      chk("m_strb_model", 64'(m_strb), 64'(q[0].s));
      chk("m_last_model", 64'(m_last), 64'(q[0].l));
    end
  endtask

  typedef struct {
    logic            sv;
    logic [c_DW-1:0] d;
    logic            la;
    logic            mr;
    logic            e_sr;
    logic            e_mv;
    logic [c_DW-1:0] e_d;
    logic            e_la;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic [c_DW-1:0] d, input logic la,
                              input logic mr, input logic e_sr, input logic e_mv,
                              input logic [c_DW-1:0] e_d, input logic e_la);
    vec_t v;
    v.sv = sv; v.d = d; v.la = la; v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_d = e_d; v.e_la = e_la;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    int cnt;
    int guard;
    int nxt;

    //          sv   data   last mr   e_sr e_mv e_data e_last
    tbl[0]  = mk(1, 32'h55, 0,   0,   1,   0,   32'h0,  0);
    tbl[1]  = mk(1, 32'h22, 0,   0,   1,   1,   32'h55, 0);
    tbl[2]  = mk(1, 32'h24, 1,   0,   1,   1,   32'h55, 0);
    tbl[3]  = mk(0, 32'h0,  0,   0,   1,   1,   32'h55, 0);
    tbl[4]  = mk(0, 32'h0,  0,   1,   1,   1,   32'h22, 0);
    tbl[5]  = mk(0, 32'h0,  0,   1,   1,   1,   32'h24, 1);
    tbl[6]  = mk(0, 32'h0,  0,   1,   1,   0,   32'h24, 1);
    tbl[7]  = mk(0, 32'h0,  0,   0,   1,   0,   32'h24, 1);
    tbl[8]  = mk(1, 32'h55, 0,   0,   1,   0,   32'h24, 1);
    tbl[9]  = mk(1, 32'h55, 0,   0,   1,   1,   32'h55, 0);
    tbl[10] = mk(1, 32'h55, 0,   0,   1,   1,   32'h55, 0);
    tbl[11] = mk(1, 32'h55, 0,   0,   1,   1,   32'h55, 0);
    tbl[12] = mk(1, 32'h55, 0,   0,   1,   1,   32'h55, 0);
    tbl[13] = mk(0, 32'h0,  0,   1,   1,   1,   32'h55, 0);
    tbl[14] = mk(0, 32'h0,  0,   1,   1,   1,   32'h55, 0);
    tbl[15] = mk(0, 32'h0,  0,   1,   1,   1,   32'h55, 0);
    tbl[16] = mk(0, 32'h0,  0,   1,   1,   1,   32'h55, 0);
    tbl[17] = mk(0, 32'h0,  0,   1,   1,   0,   32'h55, 0);

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_strb = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    n_edge = 3;
    #1;
    chk("rst_tvalid", 64'(m_valid), 64'd0);
    chk("rst_tready", 64'(s_ready), 64'd0);
    chk("rst_tdata",  64'(m_data),  64'd0);
    chk("rst_tstrb",  64'(m_strb),  64'd0);
    chk("rst_tlast",  64'(m_last),  64'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors: three-word packet, then five held writes of 0x55
    for (int i = 0; i < 18; i++) begin
      s_valid = tbl[i].sv; s_data = tbl[i].d; s_strb = 4'h1; s_last = tbl[i].la;
      m_ready = tbl[i].mr;
      step();
      chk("tbl_s_tready", 64'(s_ready), 64'(tbl[i].e_sr));
      chk("tbl_m_tvalid", 64'(m_valid), 64'(tbl[i].e_mv));
      chk("tbl_m_tdata",  64'(m_data),  64'(tbl[i].e_d));
      chk("tbl_m_tlast",  64'(m_last),  64'(tbl[i].e_la));
    end
    s_valid = 1'b0; m_ready = 1'b0;
    step();

    // Fill to capacity with no reads
    cnt = 0; guard = 0;
    s_valid = 1'b1; s_strb = 4'hF; s_last = 1'b0;
    while (cnt < c_MEM && guard < c_MEM + 100) begin
      s_data = cnt;
      if (s_ready) cnt++;
      step();
      guard++;
    end
    chk("fill_count", 64'(cnt), 64'(c_MEM));
    chk("full_tready", 64'(s_ready), 64'd0);
    s_data = 32'hDEAD_BEEF; s_last = 1'b1;
    repeat (3) step();
    chk("full_hold_tready", 64'(s_ready), 64'd0);
    chk("full_head_data", 64'(m_data), 64'd0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("tready_after_read", 64'(s_ready), 64'd1);
    chk("second_word", 64'(m_data), 64'd1);
    step();   // the held extra word is accepted now
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (c_MEM + 3) step();
    chk("drain_empty", 64'(m_valid), 64'd0);
    chk("drain_last_data", 64'(m_data), 64'hDEAD_BEEF);

    // Continuous streaming across several pointer wraps
    nxt = 0; s_valid = 1'b1; m_ready = 1'b1; s_strb = 4'h5; s_last = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      s_data = nxt;
      s_last = (nxt % 7 == 6);
      if (s_ready) nxt++;
      step();
    end
    s_valid = 1'b0;
    repeat (4) step();
    chk("stream_count", 64'(nxt), 64'd10000);

    // Random traffic with random consumer stalls
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 9) < 6);
      s_data  = $urandom;
      s_strb  = 4'($urandom_range(0, 15));
      s_last  = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 9) < 4);
      step();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (c_MEM + 3) step();

    // Reset with three words buffered
    s_valid = 1'b1; m_ready = 1'b0; s_strb = 4'h3; s_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_data = 32'hA0 + i;
      step();
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("async_rst_tvalid", 64'(m_valid), 64'd0);
    chk("async_rst_tready", 64'(s_ready), 64'd0);
    q.delete();
    active = 0;
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (5) step();
    chk("post_rst_tvalid", 64'(m_valid), 64'd0);
    s_valid = 1'b1; s_data = 32'h77; s_strb = 4'h1; s_last = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    chk("post_rst_data", 64'(m_data), 64'h77);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
